vga_sync_gen: RTL and testbench
===============================

Name: vga_sync_gen

Overview:
- Raster timing generator that produces the HCount/VCount pixel coordinates consumed by every object renderer, plus hsync, vsync and display-enable for the VGA connector.
- Divides the system clock down to the pixel rate and runs 800x525 horizontal/vertical counters (640x480 at 60 Hz by default).
- Sits at the top of the video path. Object renderers are combinational on HCount/VCount; the colour mux is gated by video_on.

Parameters:
- CLK_DIV, 2, system clocks per pixel (1..16); 2 gives 25 MHz pixels from a 50 MHz clk.
- H_DISPLAY, 640, visible pixels per line.
- H_FP, 16, horizontal front porch.
- H_SYNC, 96, horizontal sync width.
- H_BP, 48, horizontal back porch.
- V_DISPLAY, 480, visible lines.
- V_FP, 10, vertical front porch.
- V_SYNC, 2, vertical sync width.
- V_BP, 33, vertical back porch.
- SYNC_POL, 0, active level of hsync/vsync (0 = active low).

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- HCount  output  10  current pixel column, 0..H_TOTAL-1.
- VCount  output  10  current line, 0..V_TOTAL-1.
- hsync  output  1  horizontal sync, level set by SYNC_POL.
- vsync  output  1  vertical sync, level set by SYNC_POL.
- video_on  output  1  high while HCount<H_DISPLAY and VCount<V_DISPLAY.
- pixel_tick  output  1  one-clk strobe, high on the last clk of each pixel period.
- frame_start  output  1  one-clk pulse on the first clk where HCount=0 and VCount=0.

Behaviour:
- Derived totals:
  - H_TOTAL = H_DISPLAY+H_FP+H_SYNC+H_BP (800).
  - V_TOTAL = V_DISPLAY+V_FP+V_SYNC+V_BP (525).
  - Both totals must be ≤1024; out-of-range parameters are unsupported.
- Reset (sampled on the clk rising edge):
  - divider=0, HCount=0, VCount=0, pixel_tick=0, frame_start=0, video_on=0.
  - hsync=vsync=~SYNC_POL (inactive).
  - Reset asserted mid-frame aborts the frame immediately; there are no partial-state exceptions.
- Divider:
  - 0..CLK_DIV-1 counter that wraps.
  - pixel_tick is high exactly when divider==CLK_DIV-1.
  - With CLK_DIV=1, pixel_tick is high every clk after reset.
- Counters advance only on clk edges where pixel_tick=1:
  - HCount<H_TOTAL-1: HCount+1.
  - Otherwise HCount returns to 0, and VCount increments, wrapping from V_TOTAL-1 to 0.
  - HCount and VCount wrap together at (H_TOTAL-1, V_TOTAL-1) → (0,0).
- Registered decode:
  - hsync, vsync and video_on are registers computed from the next counter values.
  - They change on the same edge as HCount/VCount, so they are always consistent with the counters they accompany. There is no one-pixel skew.
- Decode windows, inclusive:
  - hsync active for HCount in [H_DISPLAY+H_FP, H_DISPLAY+H_FP+H_SYNC-1], i.e. 656..751 by default.
  - vsync active for VCount in [V_DISPLAY+V_FP, V_DISPLAY+V_FP+V_SYNC-1], i.e. 490..491 by default.
  - video_on = (HCount<H_DISPLAY)&&(VCount<V_DISPLAY).
- First clk after reset release:
  - Counters stay at (0,0) and decode registers load their (0,0) values: video_on=1, syncs inactive, frame_start=1 for that single clk.
  - frame_start then fires once per wrap to (0,0): asserted for the first clk the counters show (0,0), never for the whole pixel period.
- Timing per frame: one line = H_TOTAL pixel periods; one frame = H_TOTAL*V_TOTAL*CLK_DIV clks (840000 at defaults).
- Counters never exceed their total-1, even when parameters are changed.

Test Plan:
- Reset release, defaults:
  - Cycle 1 after release: HCount=0, VCount=0, video_on=1, hsync=vsync=1, frame_start=1.
  - pixel_tick toggles 0,1,0,1.
  - HCount=1 appears after the second clk.
- Line timing:
  - hsync falls when HCount becomes 656 and rises when HCount becomes 752.
  - video_on falls when HCount becomes 640.
  - HCount 799→0 with VCount +1 on the same edge.
- Frame timing:
  - vsync low exactly for VCount 490–491 (1600 pixel periods).
  - VCount 524→0 together with HCount 799→0; frame_start pulses once.
  - Frame period = 840000 clks.
- CLK_DIV=1, SYNC_POL=1:
  - pixel_tick constantly high; HCount increments every clk.
  - hsync high for HCount 656–751; frame period = 420000 clks.
- Reset mid-frame (HCount=300, VCount=200) held 3 clks:
  - All outputs return to reset values on the first reset edge.
  - After release, the counters restart at (0,0) and frame_start pulses.
- Checker over ≥2 full frames:
  - video_on==(HCount<640&&VCount<480) every clk.
  - HCount≤799 and VCount≤524 always.
  - No HCount change on clks with pixel_tick=0.

Source files
------------

// File: rtl/vga_sync_gen.sv
// VGA raster timing: pixel-rate divider, 800x525 counters and
// registered sync / display-enable decode aligned to the counters.
module vga_sync_gen #(
  parameter int unsigned CLK_DIV   = 2,
  parameter int unsigned H_DISPLAY = 640,
  parameter int unsigned H_FP      = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BP      = 48,
  parameter int unsigned V_DISPLAY = 480,
  parameter int unsigned V_FP      = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BP      = 33,
  parameter logic        SYNC_POL  = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  output logic [9:0] HCount,
  output logic [9:0] VCount,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic       pixel_tick,
  output logic       frame_start
);

  localparam int unsigned H_TOTAL =
    H_DISPLAY + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL =
    V_DISPLAY + V_FP + V_SYNC + V_BP;
  localparam int unsigned DW =
    (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [9:0]    H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]    V_LAST   = 10'(V_TOTAL - 1);

  // 11-bit window bounds so an end bound of 1024 still fits
  localparam logic [10:0] H_VIS  = 11'(H_DISPLAY);
  localparam logic [10:0] HS_BEG = 11'(H_DISPLAY + H_FP);
  localparam logic [10:0] HS_END = 11'(H_DISPLAY + H_FP + H_SYNC);
  localparam logic [10:0] V_VIS  = 11'(V_DISPLAY);
  localparam logic [10:0] VS_BEG = 11'(V_DISPLAY + V_FP);
  localparam logic [10:0] VS_END = 11'(V_DISPLAY + V_FP + V_SYNC);

  logic [DW-1:0] div_q, div_d;
  logic [9:0]    h_q, h_d;
  logic [9:0]    v_q, v_d;
  logic          hs_q, hs_d;
  logic          vs_q, vs_d;
  logic          vo_q, vo_d;
  logic          fs_q, fs_d;
  logic          first_q;
  logic          tick;
  logic [10:0]   hx, vx;

  always_comb begin
    // first clk after reset holds (0,0) so its decode can load
    tick  = (div_q == DIV_LAST) && !first_q;
    div_d = (div_q >= DIV_LAST) ? '0 : div_q + 1'b1;
    h_d   = h_q;
    v_d   = v_q;
    if (tick) begin
      if (h_q >= H_LAST) begin
        h_d = '0;
        v_d = (v_q >= V_LAST) ? '0 : v_q + 10'd1;
      end else begin
        h_d = h_q + 10'd1;
      end
    end
    hx   = {1'b0, h_d};
    vx   = {1'b0, v_d};
    hs_d = (hx >= HS_BEG && hx < HS_END) ? SYNC_POL : ~SYNC_POL;
    vs_d = (vx >= VS_BEG && vx < VS_END) ? SYNC_POL : ~SYNC_POL;
    vo_d = (hx < H_VIS) && (vx < V_VIS);
    fs_d = first_q ||
           (tick && h_q >= H_LAST && v_q >= V_LAST);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_q   <= '0;
      h_q     <= '0;
      v_q     <= '0;
      hs_q    <= ~SYNC_POL;
      vs_q    <= ~SYNC_POL;
      vo_q    <= 1'b0;
      fs_q    <= 1'b0;
      first_q <= 1'b1;
    end else begin
      div_q   <= div_d;
      h_q     <= h_d;
      v_q     <= v_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      vo_q    <= vo_d;
      fs_q    <= fs_d;
      first_q <= 1'b0;
    end
  end

  assign HCount      = h_q;
  assign VCount      = v_q;
  assign hsync       = hs_q;
  assign vsync       = vs_q;
  assign video_on    = vo_q;
  assign pixel_tick  = tick;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Scoreboarded bench: three configurations checked every clk against
// an arithmetic raster model indexed by clks since reset release.
module tb_vga_sync_gen;

  typedef struct packed {
    logic [9:0] h;
    logic [9:0] v;
    logic       hs;
    logic       vs;
    logic       vo;
    logic       pt;
    logic       fs;
  } obs_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [9:0] h0, v0, h1, v1, h2, v2;
  logic hs0, vs0, vo0, pt0, fs0;
  logic hs1, vs1, vo1, pt1, fs1;
  logic hs2, vs2, vo2, pt2, fs2;

  vga_sync_gen u0 (
    .clk(clk), .reset(reset),
    .HCount(h0), .VCount(v0), .hsync(hs0), .vsync(vs0),
    .video_on(vo0), .pixel_tick(pt0), .frame_start(fs0)
  );

  vga_sync_gen #(
    .CLK_DIV(3), .H_DISPLAY(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
    .V_DISPLAY(12), .V_FP(2), .V_SYNC(2), .V_BP(3), .SYNC_POL(1'b0)
  ) u1 (
    .clk(clk), .reset(reset),
    .HCount(h1), .VCount(v1), .hsync(hs1), .vsync(vs1),
    .video_on(vo1), .pixel_tick(pt1), .frame_start(fs1)
  );

  vga_sync_gen #(
    .CLK_DIV(1), .H_DISPLAY(20), .H_FP(3), .H_SYNC(5), .H_BP(4),
    .V_DISPLAY(10), .V_FP(1), .V_SYNC(3), .V_BP(2), .SYNC_POL(1'b1)
  ) u2 (
    .clk(clk), .reset(reset),
    .HCount(h2), .VCount(v2), .hsync(hs2), .vsync(vs2),
    .video_on(vo2), .pixel_tick(pt2), .frame_start(fs2)
  );

  obs_t act0, act1, act2;
  assign act0 = {h0, v0, hs0, vs0, vo0, pt0, fs0};
  assign act1 = {h1, v1, hs1, vs1, vo1, pt1, fs1};
  assign act2 = {h2, v2, hs2, vs2, vo2, pt2, fs2};

  obs_t q0[$], q1[$], q2[$];
  int vectors = 0;
  int miscompares = 0;
  int k = 0;

  // k = clk edges since reset was released (first free edge is k=1).
  // Pixel periods elapsed: one per CLK_DIV clks; with CLK_DIV=1 the
  // first edge after release does not advance.
  function automatic obs_t ref_model(
    int c, int hd, int hfp, int hsw, int hbp,
    int vd, int vfp, int vsw, int vbp, bit pol, bit rst, int kk);
    obs_t o;
    int ht, vt, p, pp, h, v;
    ht = hd + hfp + hsw + hbp;
    vt = vd + vfp + vsw + vbp;
    if (rst) begin
      o = '0;
      o.hs = !pol;
      o.vs = !pol;
      return o;
    end
    p  = kk / c - ((c == 1) ? 1 : 0);
    pp = (kk - 1) / c - ((c == 1) ? 1 : 0);
    h  = p % ht;
    v  = (p / ht) % vt;
    o.h  = 10'(h);
    o.v  = 10'(v);
    o.hs = (h >= hd + hfp && h < hd + hfp + hsw) ? pol : !pol;
    o.vs = (v >= vd + vfp && v < vd + vfp + vsw) ? pol : !pol;
    o.vo = (h < hd) && (v < vd);
    o.pt = (kk % c) == (c - 1);
    o.fs = (kk == 1) || (p != pp && p % (ht * vt) == 0);
    return o;
  endfunction

  task automatic step(input bit r);
    reset = r;
    @(posedge clk);
    if (r) k = 0;
    else k++;
    q0.push_back(ref_model(2, 640, 16, 96, 48,
                           480, 10, 2, 33, 1'b0, r, k));
    q1.push_back(ref_model(3, 16, 2, 4, 3,
                           12, 2, 2, 3, 1'b0, r, k));
    q2.push_back(ref_model(1, 20, 3, 5, 4,
                           10, 1, 3, 2, 1'b1, r, k));
    #1;
  endtask

  task automatic check(input int id, input obs_t a, input obs_t e);
    vectors++;
    if (a !== e) begin
      miscompares++;
      $display("FAIL dut%0d k=%0d got h=%0d v=%0d hs=%b vs=%b vo=%b pt=%b fs=%b want h=%0d v=%0d hs=%b vs=%b vo=%b pt=%b fs=%b",
               id, k, a.h, a.v, a.hs, a.vs, a.vo, a.pt, a.fs,
               e.h, e.v, e.hs, e.vs, e.vo, e.pt, e.fs);
    end
  endtask

  always @(negedge clk) begin
    if (q0.size() > 0) check(0, act0, q0.pop_front());
    if (q1.size() > 0) check(1, act1, q1.pop_front());
    if (q2.size() > 0) check(2, act2, q2.pop_front());
  end

  initial begin
    repeat ($urandom_range(2, 4)) step(1'b1);
    // >= 2 lines of the default raster, > 2 frames of the others
    repeat (3300 + $urandom_range(0, 300)) step(1'b0);
    repeat (3) step(1'b1);
    repeat (3000 + $urandom_range(0, 200)) step(1'b0);
    for (int r = 0; r < 6; r++) begin
      repeat ($urandom_range(1, 4)) step(1'b1);
      repeat ($urandom_range(5, 400)) step(1'b0);
    end
    @(negedge clk);
    #1;
    if (q0.size() + q1.size() + q2.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain left=%0d want=0",
               q0.size() + q1.size() + q2.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
